// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline buffer: control-bundle layout and FSM states.
package pipe_pkg;

  localparam int CTRL_W           = 7;
  localparam int CTRL_REGWRITE    = 0;
  localparam int CTRL_MEMWRITE    = 1;
  localparam int CTRL_MEMREAD     = 2;
  localparam int CTRL_MEMTOREG    = 3;
  localparam int CTRL_LOADMODE_LO = 4;
  localparam int CTRL_LOADMODE_HI = 5;
  localparam int CTRL_BRANCH      = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_mem_stage_buf_if.sv
// Valid/ready bundle carrying one EX->MEM entry; master drives the payload, slave returns ready.
interface ex_mem_stage_buf_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 7
);
  logic                  valid;
  logic                  ready;
  logic [CTRL_W-1:0]     ctrl;
  logic [DATA_W-1:0]     pc;
  logic                  zero;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     rt;
  logic [REG_ADDR_W-1:0] wb_dest;

  modport master (output valid, ctrl, pc, zero, alu_result, rt, wb_dest, input ready);
  modport slave  (input valid, ctrl, pc, zero, alu_result, rt, wb_dest, output ready);
endinterface

// File: rtl/ex_mem_stage_buf_slot.sv
// One payload register of the stage buffer: load enable, async clear to zero.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // NOTE: payload is cleared on reset so no stale fields leak out after a mid-transfer reset;
  // sequential state is always updated with <= to avoid ordering races between flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline stage: valid/ready hand-off, flush, optional 2-entry skid, bubble gating, stall counter.
module ex_mem_stage_buf #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 7,
  parameter int SKID_EN    = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  ex_mem_stage_buf_if.slave  s_ex,
  ex_mem_stage_buf_if.master m_mem,
  output logic [CNT_W-1:0]   stall_cnt
);
  import pipe_pkg::*;

  localparam int PW = CTRL_W + 3 * DATA_W + 1 + REG_ADDR_W;

  state_e            r_state;
  state_e            w_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_m;
  logic [PW-1:0]     w_in_pl;
  logic [PW-1:0]     w_m_d;
  logic [PW-1:0]     w_m_q;
  logic [CTRL_W-1:0] w_ctrl_q;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_pl     = {s_ex.ctrl, s_ex.pc, s_ex.zero, s_ex.alu_result, s_ex.rt, s_ex.wb_dest};
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = s_ex.valid & w_in_ready;
  assign w_out_fire  = w_out_valid & m_mem.ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic          r_in_ready;
      logic          w_load_s;
      logic [PW-1:0] w_s_q;

      // MEM back-pressure reaches EX only through this register, one cycle late.
      assign w_in_ready = r_in_ready;
      assign w_load_s   = !flush && (r_state == FULL) && w_in_fire && !w_out_fire;
      assign w_load_m   = !flush && ((r_state == SKID) ? w_out_fire
                                                       : (w_in_fire && ((r_state == EMPTY) || w_out_fire)));
      assign w_m_d      = (r_state == SKID) ? w_s_q : w_in_pl;

      ex_mem_slot #(.W(PW)) u_slot_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load_s),
        .i_d    (w_in_pl),
        .o_q    (w_s_q)
      );

      // NOTE: every combinational output gets a default first so no latch is inferred.
      always_comb begin
        w_nxt = r_state;
        if (flush) begin
          w_nxt = EMPTY;
        end else begin
          case (r_state)
            EMPTY:   if (w_in_fire) w_nxt = FULL;
            FULL: begin
              if (w_in_fire && !w_out_fire)      w_nxt = SKID;
              else if (!w_in_fire && w_out_fire) w_nxt = EMPTY;
            end
            SKID:    if (w_out_fire) w_nxt = FULL;
            default: w_nxt = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_in_ready <= 1'b0;
        else        r_in_ready <= (w_nxt != SKID);
      end
    end else begin : g_single
      assign w_in_ready = !w_out_valid || m_mem.ready;
      assign w_load_m   = !flush && w_in_fire;
      assign w_m_d      = w_in_pl;

      always_comb begin
        w_nxt = r_state;
        if (flush)           w_nxt = EMPTY;
        else if (w_in_fire)  w_nxt = FULL;
        else if (w_out_fire) w_nxt = EMPTY;
      end
    end
  endgenerate

  ex_mem_slot #(.W(PW)) u_slot_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load_m),
    .i_d    (w_m_d),
    .o_q    (w_m_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_out_valid && !m_mem.ready && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign s_ex.ready  = w_in_ready;
  assign m_mem.valid = w_out_valid;
  assign {w_ctrl_q, m_mem.pc, m_mem.zero, m_mem.alu_result, m_mem.rt, m_mem.wb_dest} = w_m_q;
  // An empty slot must never write a register or memory, whatever the held payload says.
  assign m_mem.ctrl  = w_out_valid ? w_ctrl_q : '0;
  assign stall_cnt   = r_stall_cnt;
endmodule
